// File: rtl/key_pkg.sv
// Shared types and counter widths for the push-button debouncer.
// Pure declarations; no timing or flow control involved.
package key_pkg;

  localparam int DB_W   = 16;
  localparam int HOLD_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: 2-flop sync, debounce FSM, hold timer; edge-to-pulse latency 2+DEBOUNCE_CYCLES.
// No backpressure: level, press, release and hold are registered and pulses last exactly one cycle.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2400,
  parameter int HOLD_CYCLES     = 24000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk_in,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_hold
);

  localparam logic              RAW_IDLE = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  // Hold counter starts at 0 on entering HELD, so this is one short of the fire point.
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - DEBOUNCE_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              s;
  key_state_t        state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              hold_pulse_q, hold_pulse_d;

  assign s = sync_q[1] ^ RAW_IDLE;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q       <= {2{RAW_IDLE}};
      state_q      <= ST_IDLE;
      db_q         <= '0;
      hold_q       <= '0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      hold_pulse_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], key_raw};
      state_q      <= state_d;
      db_q         <= db_d;
      hold_q       <= hold_d;
      press_q      <= press_d;
      release_q    <= release_d;
      hold_pulse_q <= hold_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    db_d         = db_q;
    hold_d       = hold_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    hold_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          db_d    = DB_W'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = ST_HELD;
          db_d    = '0;
          hold_d  = '0;
          press_d = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_PRE) hold_pulse_d = 1'b1;
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          db_d    = DB_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        // Hold counter is frozen here so a bounce back to HELD cannot re-fire key_hold.
        if (s) begin
          state_d = ST_HELD;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d   = ST_IDLE;
          db_d      = '0;
          hold_d    = '0;
          release_d = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign key_level   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_hold    = hold_pulse_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: N_KEYS independent channels; press/release latency 2+DEBOUNCE_CYCLES from the pin edge.
// No backpressure: all outputs are single-cycle pulses or levels, any_press is the OR of key_press.
module key_debounce #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 2400,
  parameter int HOLD_CYCLES     = 24000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold,
  output logic              any_press
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk_in     (clk_in),
      .rst        (rst),
      .key_raw    (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_hold   (key_hold[i])
    );
  end

  assign any_press = |key_press;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent push-button channels (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 2400: consecutive stable cycles required to accept a level change (2..65535).
REQ-003 SHALL have parameter HOLD_CYCLES, default 24000: cycles a key must stay accepted-pressed before key_hold fires (greater than DEBOUNCE_CYCLES, at most 2^20-1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 means raw key pin low means pressed.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port key_in, input, N_KEYS bits: raw asynchronous button pins.
REQ-008 SHALL have port key_level, output, N_KEYS bits: debounced level, 1 means pressed.
REQ-009 SHALL have port key_press, output, N_KEYS bits: one-cycle pulse on an accepted press.
REQ-010 SHALL have port key_release, output, N_KEYS bits: one-cycle pulse on an accepted release.
REQ-011 SHALL have port key_hold, output, N_KEYS bits: one-cycle pulse, at most once per press, when the hold time is reached.
REQ-012 SHALL have port any_press, output, 1 bit: OR of key_press in the same cycle.

Function
REQ-013 Each key_in bit SHALL pass a 2-flop synchronizer, then be normalised so that 1 means pressed (inverted when ACTIVE_LOW=1); call the result s.
REQ-014 Each channel SHALL run the FSM IDLE, PRESS_WAIT, HELD, RELEASE_WAIT, with a 16-bit debounce counter and a 20-bit hold counter.
REQ-015 IDLE with s=1: go to PRESS_WAIT, debounce counter to 1.
REQ-016 PRESS_WAIT with s=0: return to IDLE, counter cleared; no pulse.
REQ-017 PRESS_WAIT with s=1 and counter = DEBOUNCE_CYCLES-1: go to HELD; key_level goes to 1 and key_press pulses in the same cycle; hold counter cleared.
REQ-018 PRESS_WAIT with s=1 otherwise: increment the counter.
REQ-019 HELD: the hold counter SHALL increment each cycle and saturate at HOLD_CYCLES.
REQ-020 HELD: key_hold SHALL pulse on the cycle the hold counter first equals HOLD_CYCLES-DEBOUNCE_CYCLES, i.e. HOLD_CYCLES cycles after s first went to 1.
REQ-021 HELD with s=0: go to RELEASE_WAIT, debounce counter to 1.
REQ-022 RELEASE_WAIT with s=1: return to HELD, hold counter retained; no pulse.
REQ-023 RELEASE_WAIT with s=0 and counter = DEBOUNCE_CYCLES-1: go to IDLE; key_level goes to 0 and key_release pulses.
REQ-024 RELEASE_WAIT with s=0 otherwise: increment the counter.
REQ-025 Latency from the raw pin edge to key_press or key_release SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-026 A glitch shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change to key_level.
REQ-027 Channels SHALL be fully independent; simultaneous events on different keys SHALL each produce their own pulse in the same cycle.
REQ-028 key_press and key_release of one channel SHALL never be asserted in the same cycle.

Reset
REQ-029 While rst=1: all channels in IDLE; counters 0; synchronizer flops loaded with the released level; key_level, key_press, key_release, key_hold and any_press all 0.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL abort the channel silently, with no release pulse.
REQ-031 A key held through reset SHALL be debounced afresh after reset and produce key_press per REQ-025, counted from the cycle rst deasserts.

Structure
REQ-032 A shared package key_pkg SHALL hold the FSM state enum key_state_t and the counter width constants DB_W=16 and HOLD_W=20.
REQ-033 Per-key logic SHALL be one sub-module, key_debounce_ch, instantiated N_KEYS times in a generate loop.
REQ-034 The top level SHALL contain only the instantiation loop and the any_press reduction.

Verification (N_KEYS=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=12, ACTIVE_LOW=1)
REQ-035 key_in[0] driven 1 to 0 and held -> key_press[0] pulses exactly 6 cycles later; key_level[0]=1; any_press=1 for that one cycle.
REQ-036 key_in[1] low for 3 cycles, then high -> no pulses; key_level[1] stays 0.
REQ-037 key_in[2] held low for 20 cycles, then released cleanly -> key_press at cycle 6, key_hold once at cycle 14, key_release 6 cycles after the release edge.
REQ-038 Release bounce (high 2 cycles, low 2 cycles, then high) on a held key -> a single key_release, 6 cycles after the final high edge; key_hold not repeated.
REQ-039 Keys 0 and 3 pressed on the same cycle -> both key_press bits pulse in the same cycle; any_press high for 1 cycle.
REQ-040 rst asserted 2 cycles after a press edge, with the key still held -> all outputs 0 during reset; key_press 6 cycles after rst deasserts.
